serial_subtractor_ctrl: RTL and testbench



---
 rtl/serial_subtractor_ctrl.sv | 90 +++++++++
 tb/tb_serial_subtractor_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full-subtractor slice swept LSB-first over WIDTH
// cycles, with the borrow carried between slices in a flip-flop.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, d_sh_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, borr_q, busy_q, done_q;

  logic             d_bit, bo;
  logic [WIDTH-1:0] d_sh_d;
  logic             last;

  always_comb begin
    d_bit  = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    bo     = (~a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & br_q) | (~a_sh_q[0] & br_q);
    d_sh_d = {d_bit, d_sh_q[WIDTH-1:1]};
    last   = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      borr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          br_q   <= bo;
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          d_sh_q <= d_sh_d;
          cnt_q  <= cnt_q + 1'b1;
          if (last) begin
            // Publish the completed word; Diff/Borr stay put until the next one.
            diff_q  <= d_sh_d;
            borr_q  <= bo;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          // IDLE and DONE accept a request identically, giving back-to-back issue.
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            br_q    <= Bin_init;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Borr = borr_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random checks of serial_subtractor_ctrl at WIDTH=8.
module tb_serial_subtractor_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Bin_init = 1'b0;
  logic         busy, done, Borr;
  logic [W-1:0] Diff;

  int n_chk = 0;
  int n_fail = 0;
  int both_hi = 0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin_init(Bin_init),
    .busy(busy), .done(done), .Diff(Diff), .Borr(Borr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) both_hi++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done is seen (bounded); reports edges waited and busy cycles.
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      tick();
      n++;
    end
  endtask

  // Issues one request and checks latency, busy length and the result.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input logic [W-1:0] exp_d, input logic exp_b,
                       input bit leave);
    int n, nb;
    A = a; B = b; Bin_init = bin; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    check({tag, "_lat"}, n, W);
    check({tag, "_busy"}, nb, W);
    check({tag, "_diff"}, Diff, exp_d);
    check({tag, "_borr"}, Borr, exp_b);
    if (leave) begin
      tick();
      check({tag, "_done1"}, done, 0);
    end
  endtask

  initial begin
    int n, nb, ndone;
    logic [W:0] ref_v;
    logic [W-1:0] ra, rb;
    logic rbin;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", Diff, 0);
    check("rst_borr", Borr, 0);
    rst = 1'b0;
    tick();

    do_op("t1", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1);
    do_op("t2", 8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1);
    do_op("t3", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1);
    do_op("t4", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1);
    do_op("t5", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1);

    // start held through RUN with changing operands
    A = 8'h35; B = 8'h12; Bin_init = 1'b0; start = 1'b1;
    tick();
    ndone = 0;
    for (int i = 0; i < W - 1; i++) begin
      A = 8'($urandom); B = 8'($urandom); Bin_init = 1'($urandom);
      if (done) ndone++;
      tick();
    end
    start = 1'b0;
    tick();
    check("hold_done", done, 1);
    check("hold_diff", Diff, 8'h23);
    check("hold_borr", Borr, 0);
    for (int i = 0; i < W + 3; i++) begin
      if (done) ndone++;
      tick();
    end
    check("hold_npulse", ndone, 1);

    // back-to-back: new start issued in the DONE cycle
    do_op("b2b0", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 0);
    A = 8'h80; B = 8'h01; Bin_init = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done0", done, 0);
    tick(); tick(); tick();
    check("b2b_diff_hold", Diff, 8'h23);
    wait_done(n, nb);
    check("b2b_lat", n, W - 3);
    check("b2b_diff", Diff, 8'h7F);
    check("b2b_borr", Borr, 0);
    tick();

    // asynchronous reset after 4 bit edges
    A = 8'h12; B = 8'h35; Bin_init = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_diff", Diff, 0);
    check("arst_borr", Borr, 0);
    #1 rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("arst_idle", ndone, 0);
    do_op("arst_next", 8'hA0, 8'h0B, 1'b1, 8'h94, 1'b0, 1);

    // random sweep against an unsigned reference
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      ref_v = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
      A = ra; B = rb; Bin_init = rbin; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n, nb);
      check("rnd", {Borr, Diff}, {23'b0, ref_v});
      if (i % 2 == 0) tick();
    end

    check("busy_done_overlap", both_hi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
